// File: rtl/video_pkg.sv
// Shared definitions for the LCD panel path: default widths, the CPU-port
// FSM state type and the framebuffer size helper.
package video_pkg;

  localparam int unsigned DataWidthDef = 16;
  localparam int unsigned AddrWidthDef = 17;

  typedef enum logic [1:0] {
    CPU_IDLE,
    CPU_RD_WAIT1,
    CPU_RD_WAIT2
  } cpu_state_e;

  function automatic int unsigned FbWords(input int unsigned h_res, input int unsigned v_res);
    return h_res * v_res;
  endfunction

endpackage

// File: rtl/video_sync_delay.sv
// Parameterised N-stage delay line for de/hsync/vsync style control bits.
module video_sync_delay #(
  parameter int unsigned Stages = 3,
  parameter int unsigned Width  = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [Width-1:0] i_d,
  output logic [Width-1:0] o_q
);

  logic [Stages-1:0][Width-1:0] r_pipe;

  // Shift register; reset clears every stage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int unsigned i = 1; i < Stages; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_q = r_pipe[Stages-1];

endmodule

// File: rtl/fb_scanout_arbiter.sv
// Single-port framebuffer arbiter: scanout owns the RAM during active pixels,
// the CPU port is served only in blanking slots. Pixel data and syncs leave
// aligned to the one-cycle RAM read latency (3 cycles behind sx/sy).
module fb_scanout_arbiter
  import video_pkg::*;
#(
  parameter int unsigned HRes      = 480,
  parameter int unsigned VRes      = 272,
  parameter int unsigned AddrWidth = AddrWidthDef,
  parameter int unsigned DataWidth = DataWidthDef
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           sx,
  input  logic [9:0]           sy,
  input  logic                 hsync_in,
  input  logic                 vsync_in,
  output logic [AddrWidth-1:0] mem_addr,
  output logic                 mem_we,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic [DataWidth-1:0] mem_rdata,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [AddrWidth-1:0] cpu_addr,
  input  logic [DataWidth-1:0] cpu_wdata,
  output logic                 cpu_ack,
  output logic [DataWidth-1:0] cpu_rdata,
  output logic                 cpu_rvalid,
  output logic [DataWidth-1:0] pix,
  output logic                 de,
  output logic                 hsync_out,
  output logic                 vsync_out
);

  localparam logic [9:0]           HResPos = 10'(HRes);
  localparam logic [9:0]           VResPos = 10'(VRes);
  localparam logic [AddrWidth-1:0] FbLimit = AddrWidth'(FbWords(HRes, VRes));

  logic [AddrWidth-1:0] r_mem_addr;
  logic                 r_mem_we;
  logic [DataWidth-1:0] r_mem_wdata;
  logic [AddrWidth-1:0] r_disp_cnt;
  logic                 r_cpu_ack;
  logic [DataWidth-1:0] r_cpu_rdata;
  logic                 r_cpu_rvalid;
  logic                 r_rd_oob;
  logic [DataWidth-1:0] r_pix;
  logic                 r_de;
  logic                 r_hsync;
  logic                 r_vsync;
  cpu_state_e           r_state;
  cpu_state_e           w_state_next;

  logic                 w_active;
  logic                 w_origin;
  logic                 w_grant;
  logic                 w_cpu_in_range;
  logic [2:0]           w_sync_d2;

  assign w_active       = (sx < HResPos) && (sy < VResPos);
  assign w_origin       = (sx == '0) && (sy == '0);
  // Grant and RAM slot share the same sampled w_active, so they cannot collide.
  assign w_grant        = (r_state == CPU_IDLE) && !w_active && cpu_req;
  assign w_cpu_in_range = cpu_addr < FbLimit;

  // CPU FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= CPU_IDLE;
    else     r_state <= w_state_next;
  end

  // CPU FSM next state: a granted read occupies two wait cycles.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      CPU_IDLE:     if (w_grant && !cpu_we) w_state_next = CPU_RD_WAIT1;
      CPU_RD_WAIT1: w_state_next = CPU_RD_WAIT2;
      CPU_RD_WAIT2: w_state_next = CPU_IDLE;
      default:      w_state_next = CPU_IDLE;
    endcase
  end

  // RAM port: scanout address during active pixels, CPU slot otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wdata <= '0;
      r_disp_cnt  <= '0;
      r_cpu_ack   <= 1'b0;
    end else begin
      r_mem_we  <= 1'b0;
      r_cpu_ack <= 1'b0;
      if (w_active) begin
        if (w_origin) begin
          r_mem_addr <= '0;
          r_disp_cnt <= AddrWidth'(1);
        end else begin
          r_mem_addr <= r_disp_cnt;
          r_disp_cnt <= r_disp_cnt + AddrWidth'(1);
        end
      end else if (w_grant) begin
        r_mem_addr  <= cpu_addr;
        r_mem_we    <= cpu_we && w_cpu_in_range;
        r_mem_wdata <= cpu_wdata;
        r_cpu_ack   <= 1'b1;
      end
    end
  end

  // CPU read return: remember out-of-range at grant, capture in RD_WAIT2.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_rdata  <= '0;
      r_cpu_rvalid <= 1'b0;
      r_rd_oob     <= 1'b0;
    end else begin
      r_cpu_rvalid <= 1'b0;
      if (w_grant && !cpu_we) r_rd_oob <= !w_cpu_in_range;
      if (r_state == CPU_RD_WAIT2) begin
        r_cpu_rdata  <= r_rd_oob ? '0 : mem_rdata;
        r_cpu_rvalid <= 1'b1;
      end
    end
  end

  // Two delay stages here plus the output register below make the 3-cycle lag;
  // pix needs de one stage early to gate the RAM data.
  video_sync_delay #(
    .Stages(2),
    .Width (3)
  ) u_sync_dly (
    .i_clk(clk),
    .i_rst(rst),
    .i_d  ({w_active, hsync_in, vsync_in}),
    .o_q  (w_sync_d2)
  );

  // Panel output register: pix forced to zero outside data-enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix   <= '0;
      r_de    <= 1'b0;
      r_hsync <= 1'b0;
      r_vsync <= 1'b0;
    end else begin
      r_pix   <= w_sync_d2[2] ? mem_rdata : '0;
      r_de    <= w_sync_d2[2];
      r_hsync <= w_sync_d2[1];
      r_vsync <= w_sync_d2[0];
    end
  end

  assign mem_addr   = r_mem_addr;
  assign mem_we     = r_mem_we;
  assign mem_wdata  = r_mem_wdata;
  assign cpu_ack    = r_cpu_ack;
  assign cpu_rdata  = r_cpu_rdata;
  assign cpu_rvalid = r_cpu_rvalid;
  assign pix        = r_pix;
  assign de         = r_de;
  assign hsync_out  = r_hsync;
  assign vsync_out  = r_vsync;

endmodule

// File: tb/tb_fb_scanout_arbiter.sv
// Bench for fb_scanout_arbiter: drives a video raster plus directed and random
// CPU traffic, and compares every cycle against a reference model built from
// raster position (address = sy*HRes+sx) and a transaction-level CPU port.
module tb_fb_scanout_arbiter;

  localparam int HRES = 480;
  localparam int VRES = 272;
  localparam int HTOT = 490;
  localparam int VTOT = 276;
  localparam int FBW  = HRES * VRES;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  sx, sy;
  logic        hsync_in, vsync_in;
  logic [16:0] mem_addr;
  logic        mem_we;
  logic [15:0] mem_wdata, mem_rdata;
  logic        cpu_req, cpu_we;
  logic [16:0] cpu_addr;
  logic [15:0] cpu_wdata;
  logic        cpu_ack, cpu_rvalid;
  logic [15:0] cpu_rdata, pix;
  logic        de, hsync_out, vsync_out;

  always #5 clk = ~clk;

  fb_scanout_arbiter #(
    .HRes(HRES), .VRes(VRES), .AddrWidth(17), .DataWidth(16)
  ) dut (
    .clk(clk), .rst(rst), .sx(sx), .sy(sy), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .pix(pix), .de(de), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  // RAM: one-cycle read latency, unwritten words hold addr[15:0].
  logic [15:0] ram_w [int];
  function automatic logic [15:0] ram_rd(input logic [16:0] a);
    if (ram_w.exists(int'(a))) return ram_w[int'(a)];
    return a[15:0];
  endfunction
  always @(posedge clk) begin
    mem_rdata <= ram_rd(mem_addr);
    if (mem_we === 1'b1) ram_w[int'(mem_addr)] = mem_wdata;
  end

  // Reference model state.
  typedef struct { logic de; logic hs; logic vs; int addr; } prec_t;
  prec_t       pq[$];
  logic [15:0] exp_w [int];
  logic [16:0] e_addr;
  logic        e_we, e_ack, e_rvalid, e_de, e_hs, e_vs;
  logic [15:0] e_wdata, e_rdata, e_pix;
  int          busy, rd_addr, pw_addr;
  bit          rd_oob, pw_valid, m_gnt, m_rst;
  logic [15:0] pw_data;
  int          n_cmp = 0;
  int          n_fail = 0;
  int          gx, gy;

  function automatic logic [15:0] exp_rd(input int a);
    logic [31:0] v;
    if (exp_w.exists(a)) return exp_w[a];
    v = 32'(a);
    return v[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (x=%0d y=%0d t=%0t)", tag, obs, exp, gx, gy, $time);
    end
  endtask

  task automatic pipe_clear();
    pq = {};
    pq.push_back('{1'b0, 1'b0, 1'b0, 0});
    pq.push_back('{1'b0, 1'b0, 1'b0, 0});
  endtask

  // One clock: update the model from the sampled inputs, then check outputs.
  task automatic step();
    prec_t r;
    bit    act;
    @(posedge clk);
    act   = (int'(sx) < HRES) && (int'(sy) < VRES);
    m_gnt = 1'b0;
    m_rst = (rst === 1'b1);
    if (m_rst) begin
      e_addr = '0; e_we = 0; e_wdata = '0; e_ack = 0; e_rvalid = 0; e_rdata = '0;
      e_pix = '0; e_de = 0; e_hs = 0; e_vs = 0;
      pipe_clear();
      busy = 0;
    end else begin
      e_ack = 0; e_we = 0; e_rvalid = 0;
      r = pq.pop_front();
      e_de = r.de; e_hs = r.hs; e_vs = r.vs;
      e_pix = r.de ? exp_rd(r.addr) : 16'h0;
    end
    // A write issued last cycle lands in RAM on this edge.
    if (pw_valid) begin
      exp_w[pw_addr] = pw_data;
      pw_valid = 0;
    end
    if (!m_rst) begin
      if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          e_rvalid = 1;
          e_rdata  = rd_oob ? 16'h0 : exp_rd(rd_addr);
        end
      end else if (cpu_req && !act) begin
        m_gnt   = 1;
        e_ack   = 1;
        e_addr  = cpu_addr;
        e_wdata = cpu_wdata;
        e_we    = cpu_we && (int'(cpu_addr) < FBW);
        if (e_we) begin
          pw_valid = 1; pw_addr = int'(cpu_addr); pw_data = cpu_wdata;
        end
        if (!cpu_we) begin
          busy = 2; rd_addr = int'(cpu_addr); rd_oob = !(int'(cpu_addr) < FBW);
        end
      end
      if (act) e_addr = 17'(int'(sy) * HRES + int'(sx));
      r.de = act; r.hs = hsync_in; r.vs = vsync_in; r.addr = int'(sy) * HRES + int'(sx);
      pq.push_back(r);
    end
    #1;
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("cpu_ack", 32'(cpu_ack), 32'(e_ack));
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(e_rvalid));
    chk("de", 32'(de), 32'(e_de));
    chk("pix", 32'(pix), 32'(e_pix));
    chk("hsync_out", 32'(hsync_out), 32'(e_hs));
    chk("vsync_out", 32'(vsync_out), 32'(e_vs));
    if (e_ack || m_rst) chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
    if (e_rvalid || m_rst) chk("cpu_rdata", 32'(cpu_rdata), 32'(e_rdata));
    if (m_gnt) cpu_req = 1'b0;
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      sx = 10'(gx); sy = 10'(gy);
      hsync_in = (gx >= 482) && (gx < 486);
      vsync_in = (gy == 273);
      step();
      gx++;
      if (gx == HTOT) begin
        gx = 0; gy++;
        if (gy == VTOT) gy = 0;
      end
    end
  endtask

  task automatic run_to(input int x, input int y);
    int guard = 0;
    while (!(gx == x && gy == y)) begin
      adv(1);
      guard++;
      if (guard > 20000) begin
        $display("FAIL run_to position (%0d,%0d) not reached, at (%0d,%0d)", x, y, gx, gy);
        $fatal(1);
      end
    end
  endtask

  task automatic issue(input bit we, input int addr, input logic [15:0] d);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = 17'(addr); cpu_wdata = d;
  endtask

  initial begin
    rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    sx = '0; sy = '0; hsync_in = 0; vsync_in = 0;
    busy = 0; pw_valid = 0; rd_oob = 0; rd_addr = 0;
    e_addr = '0; e_we = 0; e_wdata = '0; e_ack = 0; e_rvalid = 0; e_rdata = '0;
    e_pix = '0; e_de = 0; e_hs = 0; e_vs = 0;
    pipe_clear();

    // Reset held five cycles mid-frame.
    gx = 100; gy = 5;
    adv(5);
    // Release in vertical blanking, then start a fresh frame.
    gx = 0; gy = 272;
    rst = 1'b0;
    adv(30);
    gx = 0; gy = 0;

    // CPU write in the blanking slot of line 0.
    run_to(481, 0);
    issue(1'b1, 100, 16'hF800);
    adv(1);

    // CPU read requested during active video: waits for sx=480.
    run_to(10, 3);
    issue(1'b0, int'($urandom_range(0, FBW - 1)), 16'h0);
    run_to(0, 4);

    // Read back the word written above.
    run_to(483, 4);
    issue(1'b0, 100, 16'h0);
    adv(5);

    // Out-of-range write and read.
    issue(1'b1, FBW, 16'h1234);
    adv(1);
    issue(1'b0, 130600, 16'h0);
    run_to(0, 6);

    // Reset while a read sits in its first wait cycle.
    run_to(481, 6);
    issue(1'b0, 200, 16'h0);
    adv(1);
    rst = 1'b1;
    adv(2);
    rst = 1'b0;
    gx = 0; gy = 272;
    adv(10);
    issue(1'b0, 300, 16'h0);
    adv(6);

    // New frame from origin: line 0 now shows the written pixel at 100.
    gx = 0; gy = 0;
    for (int i = 0; i < 8 * HTOT; i++) begin
      if (!cpu_req && $urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 7) == 0)
          issue(1'($urandom_range(0, 1)), FBW + int'($urandom_range(0, 511)), 16'($urandom));
        else
          issue(1'($urandom_range(0, 1)), int'($urandom_range(0, FBW - 1)), 16'($urandom));
      end
      adv(1);
    end
    adv(HTOT + 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
